// File: rtl/io_in8_if.sv
// Peripheral bus bundle for the io_in8 input port: write strobe, 2-bit address,
// 32-bit write/read data and the level interrupt.
interface io_in8_if;
  logic        WE;
  logic [1:0]  ADDR;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        IRQ;

  modport master (output WE, ADDR, DATA_IN, input DATA_OUT, IRQ);
  modport slave  (input WE, ADDR, DATA_IN, output DATA_OUT, IRQ);
endinterface

// File: rtl/io_in8.sv
// 8-bit CPU-readable input port: 2-flop synchronizer, optional per-bit debounce
// (enabled by macro IO_IN8_DEBOUNCE_EN), edge detection into W1C flags and IRQ.
module io_in8 #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IO_IN,
  io_in8_if.slave    bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || (2**CNT_W) <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("io_in8: DEBOUNCE_CYCLES must be 1..65535 and fit in CNT_W bits");
  end

  logic [7:0] sync_p0;
  logic [7:0] sync_p1;
  logic [7:0] stable_p2;
  logic [7:0] stable_nxt;
  logic [7:0] flags;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic [7:0] rise;
  logic [7:0] fall;
  logic [7:0] set_ev;
  logic       unused_din;

  assign unused_din = ^bus.DATA_IN[31:8];

  // Stage p0/p1: two-flop synchronizer for the asynchronous pins
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= IO_IN;
      sync_p1 <= sync_p0;
    end
  end

`ifdef IO_IN8_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0][CNT_W-1:0] cnt;
  logic [7:0][CNT_W-1:0] cnt_nxt;

  // Each bit counts consecutive disagreeing samples; any agreement restarts it.
  always_comb begin
    stable_nxt = stable_p2;
    cnt_nxt    = cnt;
    for (int i = 0; i < 8; i++) begin
      if (sync_p1[i] == stable_p2[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = sync_p1[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt <= '0;
    else       cnt <= cnt_nxt;
  end
`else
  assign stable_nxt = sync_p1;
`endif

  // Stage p2: debounced value; events are taken from the transition being committed
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) stable_p2 <= '0;
    else       stable_p2 <= stable_nxt;
  end

  assign rise   = stable_nxt & ~stable_p2;
  assign fall   = ~stable_nxt & stable_p2;
  assign set_ev = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags   <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      // A new event on the same edge as its clear keeps the flag set.
      if (bus.WE && bus.ADDR == 2'd1) flags <= (flags & ~bus.DATA_IN[7:0]) | set_ev;
      else                            flags <= flags | set_ev;
      if (bus.WE && bus.ADDR == 2'd2) rise_en <= bus.DATA_IN[7:0];
      if (bus.WE && bus.ADDR == 2'd3) fall_en <= bus.DATA_IN[7:0];
    end
  end

  always_comb begin
    bus.DATA_OUT = '0;
    case (bus.ADDR)
      2'd0: bus.DATA_OUT = {24'b0, stable_p2};
      2'd1: bus.DATA_OUT = {24'b0, flags};
      2'd2: bus.DATA_OUT = {24'b0, rise_en};
      2'd3: bus.DATA_OUT = {24'b0, fall_en};
      default: bus.DATA_OUT = '0;
    endcase
  end

  assign bus.IRQ = |flags;

endmodule

// File: tb/tb_io_in8.sv
// Self-checking bench for io_in8: directed scenarios with literal expectations,
// then randomized pins/writes/resets checked every cycle against a queue-based model.
module tb_io_in8;
`ifdef IO_IN8_DEBOUNCE_EN
  localparam int D = 16;
`else
  localparam int D = 1;
`endif
  localparam int L = D + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] io_in = 8'h00;
  int         checks = 0;
  int         errors = 0;
  bit         cmp_on = 1'b0;

  io_in8_if bus();

  io_in8 #(.DEBOUNCE_CYCLES(16), .CNT_W(16)) dut (
    .CLK  (clk),
    .RESET(rst),
    .IO_IN(io_in),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pins pass two sample delays, then STABLE flips a bit only
  // when the last D sampled values of that bit all disagree with it.
  logic [7:0] m_s1 = 0, m_s2 = 0, m_stable = 0, m_flags = 0, m_ren = 0, m_fen = 0;
  logic [7:0] hist[$];
  logic [7:0] nst, setv;
  bit         all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_flags = 0; m_ren = 0; m_fen = 0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      nst = m_stable;
      if (hist.size() == D) begin
        for (int i = 0; i < 8; i++) begin
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) nst[i] = ~m_stable[i];
        end
      end
      setv = ((nst & ~m_stable) & m_ren) | ((~nst & m_stable) & m_fen);
      if (bus.WE && bus.ADDR == 2'd1) m_flags = (m_flags & ~bus.DATA_IN[7:0]) | setv;
      else                            m_flags = m_flags | setv;
      if (bus.WE && bus.ADDR == 2'd2) m_ren = bus.DATA_IN[7:0];
      if (bus.WE && bus.ADDR == 2'd3) m_fen = bus.DATA_IN[7:0];
      m_stable = nst;
      m_s2 = m_s1;
      m_s1 = io_in;
    end
  end

  function automatic logic [31:0] mread(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_stable};
      2'd1:    return {24'b0, m_flags};
      2'd2:    return {24'b0, m_ren};
      default: return {24'b0, m_fen};
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      checks++;
      if (bus.DATA_OUT !== mread(bus.ADDR)) begin
        errors++;
        $display("FAIL model_rd_addr%0d got %h exp %h", bus.ADDR, bus.DATA_OUT, mread(bus.ADDR));
      end
      checks++;
      if (bus.IRQ !== (|m_flags)) begin
        errors++;
        $display("FAIL model_irq got %b exp %b", bus.IRQ, |m_flags);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.WE   = 1'b0;
    bus.ADDR = a;
    #1;
    d = bus.DATA_OUT;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.WE      = 1'b1;
    bus.ADDR    = a;
    bus.DATA_IN = d;
    cyc();
    bus.WE      = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] pins);
    rst   = 1'b1;
    io_in = pins;
    bus.WE = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    bus.WE = 1'b0; bus.ADDR = 2'd0; bus.DATA_IN = '0;
    #1 rst = 1'b1;
    cmp_on = 1'b1;

    // Power-up with pins at A5: STABLE follows after the full latency, no flags
    do_reset(8'hA5);
    for (int k = 1; k <= L; k++) begin
      cyc();
      if (k == 1) begin rd(2'd0, r); chk("a5_early", r, 32'h0); end
      if (k == L - 1) begin rd(2'd0, r); chk("a5_before", r, 32'h0); end
      if (k == L) begin
        rd(2'd0, r); chk("a5_stable", r, 32'h000000A5);
        rd(2'd1, r); chk("a5_flags", r, 32'h0);
        chk("a5_irq", {31'b0, bus.IRQ}, 32'h0);
      end
    end

    // Rise on 0 -> 3C with RISE_EN=FF, then W1C clear
    do_reset(8'h00);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, r); chk("rise_en_rd", r, 32'h000000FF);
    repeat (L + 2) cyc();
    io_in = 8'h3C;
    for (int k = 1; k <= L; k++) begin
      cyc();
      if (k == L - 1) begin rd(2'd1, r); chk("3c_flags_before", r, 32'h0); end
      if (k == L) begin
        rd(2'd0, r); chk("3c_stable", r, 32'h0000003C);
        rd(2'd1, r); chk("3c_flags", r, 32'h0000003C);
        chk("3c_irq", {31'b0, bus.IRQ}, 32'h1);
      end
    end
    wr(2'd1, 32'h0000_003C);
    rd(2'd1, r); chk("w1c_flags", r, 32'h0);
    chk("w1c_irq", {31'b0, bus.IRQ}, 32'h0);

    // Same-edge W1C and new rise on bit 2: set wins
    io_in = 8'h38;
    repeat (L + 2) cyc();
    rd(2'd1, r); chk("fall_disabled", r, 32'h0);
    io_in = 8'h3C;
    repeat (L - 1) cyc();
    wr(2'd1, 32'h0000_0004);
    rd(2'd1, r); chk("set_wins", r, 32'h00000004);
    wr(2'd1, 32'h0000_00FF);
    rd(2'd1, r); chk("clear_all", r, 32'h0);

    // Fall on bit 7: a too-short low pulse is ignored, a long one flags
    wr(2'd2, 32'h0);
    wr(2'd3, 32'h80);
    io_in = 8'hBC;
    repeat (L + 2) cyc();
    io_in[7] = 1'b0;
    repeat (D - 1) cyc();
    io_in[7] = 1'b1;
    repeat (L + 2) cyc();
    rd(2'd1, r); chk("glitch_ignored", r, 32'h0);
    io_in[7] = 1'b0;
    repeat (D + L + 2) cyc();
    rd(2'd1, r); chk("fall_flag", r, 32'h00000080);
    chk("fall_irq", {31'b0, bus.IRQ}, 32'h1);
    wr(2'd3, 32'h0);
    rd(2'd1, r); chk("en_clear_keeps_flag", r, 32'h00000080);

    // Randomized traffic checked by the per-cycle compare process
    for (int n = 0; n < 6000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 15) == 0) io_in[b] = ~io_in[b];
      if ($urandom_range(0, 5) == 0) begin
        bus.WE      = 1'b1;
        bus.ADDR    = 2'($urandom_range(0, 3));
        bus.DATA_IN = $urandom;
      end else begin
        bus.WE   = 1'b0;
        bus.ADDR = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end
    bus.WE = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
